// File: rtl/z3_target_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : z3_target_sequencer_if
// Description : Bundle of Zorro III slave-cycle signals between the buffered
//               bus/decode logic (master side) and z3_target_sequencer
//               (slave side).
//   master drives : FCS_n, READ, DS_n[3:0], validspace, sel[NT-1:0], ack[NT-1:0]
//   slave drives  : grant[NT-1:0], dtack, dout_en, tmo, tmo_cnt[7:0], busy
// Revision    : 1.0 - initial release
// ============================================================================
interface z3_target_sequencer_if #(
  parameter int NT = 5
);
  logic          FCS_n;
  logic          READ;
  logic [3:0]    DS_n;
  logic          validspace;
  logic [NT-1:0] sel;
  logic [NT-1:0] ack;
  logic [NT-1:0] grant;
  logic          dtack;
  logic          dout_en;
  logic          tmo;
  logic [7:0]    tmo_cnt;
  logic          busy;

  modport master (
    output FCS_n, READ, DS_n, validspace, sel, ack,
    input  grant, dtack, dout_en, tmo, tmo_cnt, busy
  );

  modport slave (
    input  FCS_n, READ, DS_n, validspace, sel, ack,
    output grant, dtack, dout_en, tmo, tmo_cnt, busy
  );
endinterface
`default_nettype wire

// File: rtl/z3_target_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : z3_target_sequencer
// Description : Arbitrates every Zorro III slave cycle addressed to the board.
//               Grants the data bus to one local target (IACK, AUTOCFG, SCSI,
//               ROM, IDREG; lowest index wins), waits for that target's ack and
//               then holds a registered DTACK request until FCS_n negates.
// Ports       : CLK      - board clock, all state on the rising edge
//               RESET_n  - asynchronous active-low reset
//               bus      - z3_target_sequencer_if slave modport
//                          (FCS_n/READ/DS_n/validspace/sel/ack in,
//                           grant/dtack/dout_en/tmo/tmo_cnt/busy out)
// Config      : define TARGET_TIMEOUT_EN to force termination of a cycle after
//               TMO_CYCLES clocks in DATA without an ack (tmo/tmo_cnt active).
//               Undefined: DATA waits forever, tmo and tmo_cnt are tied 0.
// Revision    : 1.0 - initial release
// ============================================================================
module z3_target_sequencer #(
  parameter int NT         = 5,
  parameter int TMO_CYCLES = 64,
  parameter int CNT_W      = 7
) (
  input wire CLK,
  input wire RESET_n,
  z3_target_sequencer_if.slave bus
);

  // Reject configurations where the wait counter cannot reach its terminal value.
  generate
    if (TMO_CYCLES < 2 || (TMO_CYCLES - 1) >= (1 << CNT_W)) begin : g_bad_cfg
      $error("z3_target_sequencer: TMO_CYCLES/CNT_W combination invalid");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_END   = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [NT-1:0] r_grant, w_grant_nxt;
  logic          r_dtack, w_dtack_nxt;
  logic [NT-1:0] w_sel_lsb;
  logic          w_hit;

`ifdef TARGET_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_tmo, w_tmo_nxt;
  logic [7:0]       r_tmo_cnt, w_tmo_cnt_nxt;
`endif

  // Isolate the lowest set sel bit: x & -x.
  assign w_sel_lsb = bus.sel & (~bus.sel + {{(NT-1){1'b0}}, 1'b1});
  // Only the granted target's ack counts.
  assign w_hit     = |(bus.ack & r_grant);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_dtack_nxt = r_dtack;
`ifdef TARGET_TIMEOUT_EN
    w_cnt_nxt     = r_cnt;
    w_tmo_nxt     = r_tmo;
    w_tmo_cnt_nxt = r_tmo_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        w_grant_nxt = '0;
        w_dtack_nxt = 1'b0;
`ifdef TARGET_TIMEOUT_EN
        w_tmo_nxt   = 1'b0;
`endif
        if (!bus.FCS_n && bus.validspace && (|bus.sel)) begin
          w_grant_nxt = w_sel_lsb;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (bus.FCS_n) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
        end else if (bus.READ || (bus.DS_n != 4'hF)) begin
          // Writes wait here until a data strobe shows valid data.
          w_state_nxt = S_DATA;
`ifdef TARGET_TIMEOUT_EN
          w_cnt_nxt   = '0;
`endif
        end
      end
      S_DATA: begin
        if (bus.FCS_n) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
        end else if (w_hit) begin
          w_state_nxt = S_END;
          w_dtack_nxt = 1'b1;
`ifdef TARGET_TIMEOUT_EN
          w_tmo_nxt   = 1'b0;
`endif
        end
`ifdef TARGET_TIMEOUT_EN
        else if (r_cnt == CNT_W'(TMO_CYCLES - 1)) begin
          // Forced termination so a silent target cannot hang the bus.
          w_state_nxt = S_END;
          w_dtack_nxt = 1'b1;
          w_tmo_nxt   = 1'b1;
          if (r_tmo_cnt != 8'hFF) begin
            w_tmo_cnt_nxt = r_tmo_cnt + 8'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
`endif
      end
      S_END: begin
        if (bus.FCS_n) begin
          w_state_nxt = S_IDLE;
          w_dtack_nxt = 1'b0;
          w_grant_nxt = '0;
`ifdef TARGET_TIMEOUT_EN
          w_tmo_nxt   = 1'b0;
`endif
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
        w_dtack_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_dtack   <= 1'b0;
`ifdef TARGET_TIMEOUT_EN
      r_cnt     <= '0;
      r_tmo     <= 1'b0;
      r_tmo_cnt <= 8'h00;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_dtack   <= w_dtack_nxt;
`ifdef TARGET_TIMEOUT_EN
      r_cnt     <= w_cnt_nxt;
      r_tmo     <= w_tmo_nxt;
      r_tmo_cnt <= w_tmo_cnt_nxt;
`endif
    end
  end

  assign bus.grant   = r_grant;
  assign bus.dtack   = r_dtack;
  assign bus.dout_en = r_dtack & bus.READ;
  assign bus.busy    = (r_state != S_IDLE);
`ifdef TARGET_TIMEOUT_EN
  assign bus.tmo     = r_tmo;
  assign bus.tmo_cnt = r_tmo_cnt;
`else
  assign bus.tmo     = 1'b0;
  assign bus.tmo_cnt = 8'h00;
`endif

endmodule
`default_nettype wire
